write_back_stage: RTL and testbench
===================================

Name: write_back_stage

Overview:
Registered write-back stage: the MEM/WB pipeline latch and write-back data selection in one block.
- Selects among ALU result, load data and PC return.
- Extends sub-word loads (byte/half, signed/unsigned) from the memory word.
- Drives the register-file write port one cycle after capture.
- Supports stall and flush from the hazard unit and an optional retired-instruction counter for the debug unit.

Parameters:
PROC_BITS, 32, datapath width; power of two, >=16.
PC_BITS, 32, return-address width; <= PROC_BITS, zero-extended to PROC_BITS.
REG_ADDRS_BITS, 5, register address width.
CNT_BITS, 32, retired counter width (optional feature only).
OFF_BITS, $clog2(PROC_BITS/8), derived localparam, byte-offset width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-low reset.
i_stall  in  1  hold all registered state.
i_flush  in  1  replace captured instruction with a bubble.
i_valid  in  1  incoming instruction is valid.
i_RegWrite  in  1  instruction writes a register.
i_reg_addr  in  REG_ADDRS_BITS  destination register.
i_wb_sel  in  2  00 ALU, 01 MEM, 10 PC return, 11 treated as ALU.
i_load_size  in  2  00 byte, 01 half, 10/11 full word.
i_load_unsigned  in  1  1 zero-extend, 0 sign-extend.
i_byte_offset  in  OFF_BITS  load address low bits.
i_alu_data  in  PROC_BITS  ALU result.
i_mem_data  in  PROC_BITS  raw memory word.
i_pc_return  in  PC_BITS  link address.
o_reg_data  out  PROC_BITS  register write data.
o_reg_addr  out  REG_ADDRS_BITS  register write address.
o_reg_write  out  1  register write enable.
o_valid  out  1  valid instruction in WB.

Behaviour:
- Reset (rst=0, async): every output is 0, including the counter. Release is taken synchronously on the next edge.
- Latency: one cycle. Inputs are captured on a rising edge; outputs reflect them until the next capture.
- Edge priority: reset > flush > stall > capture.
- Flush: o_valid=0, o_reg_write=0, o_reg_data=0, o_reg_addr=0, regardless of stall.
- Stall (no flush): all outputs hold their values. A held o_reg_write=1 re-asserts the same write; this is idempotent and intended.
- Capture: o_valid<=i_valid.
- Capture: o_reg_write<=i_valid & i_RegWrite & (i_reg_addr!=0). Writes to r0 are suppressed, but o_valid still reflects i_valid.
- Capture: o_reg_addr<=i_reg_addr.
- Capture: o_reg_data<=the selected value below, computed combinationally from the current inputs.
- Load extension, for MEM selection only:
  - byte: lane = i_mem_data[8*i_byte_offset +: 8], extended to PROC_BITS.
  - half: lane index = i_byte_offset[OFF_BITS-1:1], i.e. bits [16*idx +: 16]. Bit 0 of the offset is ignored; a misaligned half uses the containing aligned half.
  - full: i_mem_data as-is; offset ignored.
  - Sign extension replicates the lane MSB; unsigned pads with zeros.
- PC selection: i_pc_return zero-extended to PROC_BITS.
- Invalid inputs (i_valid=0) still capture data/address fields, but o_reg_write=0.

Optional Feature:
Macro WB_RETIRE_COUNT_EN.
- Defined: adds port i_count_clr (in, 1, synchronous clear) and port o_retired_count (out, CNT_BITS).
  - Increments by 1 on each capture edge with i_valid=1, no stall, no flush.
  - Wraps from all-ones to 0.
  - Clear and increment on the same edge: result is 0.
  - Clear is honoured during stall.
  - Async reset sets the counter to 0.
- Undefined: neither port exists; no counter logic.

Test Plan:
1. Reset mid-stream: assert rst=0 while o_reg_write=1 -> all outputs 0 immediately, before any clock edge; first capture after release works.
2. Signed byte load: i_wb_sel=01, size=00, unsigned=0, offset=2, mem=0x1280_3456, addr=7, RegWrite=1, valid=1 -> next cycle o_reg_data=0xFFFF_FF80, o_reg_addr=7, o_reg_write=1.
3. Half loads, mem=0x8001_7FFE: unsigned, offset=3 -> 0x0000_8001; signed, offset=0 -> 0x0000_7FFE; full word, offset=1 -> 0x8001_7FFE.
4. r0 and PC selection: wb_sel=10, pc=0x0000_0040, addr=0, RegWrite=1 -> o_reg_write=0, o_valid=1. Repeat with addr=31 -> o_reg_data=0x40, o_reg_write=1.
5. Stall then flush: capture ALU 0xDEAD_BEEF, then stall 3 cycles with changing inputs -> outputs hold 0xDEAD_BEEF. Then assert flush and stall together -> o_valid=0, o_reg_write=0, o_reg_data=0.
6. Counter (macro defined): 5 valid captures, 1 stalled cycle and 1 flushed cycle -> count=5. Preload to all-ones and do 1 capture -> count=0. i_count_clr together with a capture -> count=0.

Source files
------------

// File: rtl/write_back_stage.sv
// MEM/WB latch with write-back select and sub-word load extension; optional retired counter under WB_RETIRE_COUNT_EN.
// Latency: one cycle from capture edge to register-file write port.
// Backpressure: i_stall holds every registered output; i_flush overrides stall and inserts a bubble.
module write_back_stage #(
    parameter int PROC_BITS      = 32,
    parameter int PC_BITS        = 32,
    parameter int REG_ADDRS_BITS = 5,
    parameter int CNT_BITS       = 32,
    localparam int OFF_BITS      = $clog2(PROC_BITS/8)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic                      i_valid,
    input  logic                      i_RegWrite,
    input  logic [REG_ADDRS_BITS-1:0] i_reg_addr,
    input  logic [1:0]                i_wb_sel,
    input  logic [1:0]                i_load_size,
    input  logic                      i_load_unsigned,
    input  logic [OFF_BITS-1:0]       i_byte_offset,
    input  logic [PROC_BITS-1:0]      i_alu_data,
    input  logic [PROC_BITS-1:0]      i_mem_data,
    input  logic [PC_BITS-1:0]        i_pc_return,
`ifdef WB_RETIRE_COUNT_EN
    input  logic                      i_count_clr,
    output logic [CNT_BITS-1:0]       o_retired_count,
`endif
    output logic [PROC_BITS-1:0]      o_reg_data,
    output logic [REG_ADDRS_BITS-1:0] o_reg_addr,
    output logic                      o_reg_write,
    output logic                      o_valid
);

    logic [OFF_BITS-1:0]       half_idx;
    logic [7:0]                byte_lane;
    logic [15:0]               half_lane;
    logic [PROC_BITS-1:0]      load_data;
    logic [PROC_BITS-1:0]      sel_data;

    logic [PROC_BITS-1:0]      reg_data_q, reg_data_d;
    logic [REG_ADDRS_BITS-1:0] reg_addr_q, reg_addr_d;
    logic                      reg_write_q, reg_write_d;
    logic                      valid_q, valid_d;

    // A misaligned half falls back to the aligned half that contains it.
    always_comb begin
        half_idx  = i_byte_offset >> 1;
        byte_lane = i_mem_data[{i_byte_offset, 3'b000} +: 8];
        half_lane = i_mem_data[{half_idx, 4'b0000} +: 16];
        case (i_load_size)
            2'b00:   load_data = i_load_unsigned ? {{(PROC_BITS-8){1'b0}}, byte_lane}
                                                 : {{(PROC_BITS-8){byte_lane[7]}}, byte_lane};
            2'b01:   load_data = i_load_unsigned ? {{(PROC_BITS-16){1'b0}}, half_lane}
                                                 : {{(PROC_BITS-16){half_lane[15]}}, half_lane};
            default: load_data = i_mem_data;
        endcase
        case (i_wb_sel)
            2'b01:   sel_data = load_data;
            2'b10:   sel_data = PROC_BITS'(i_pc_return);
            default: sel_data = i_alu_data;
        endcase
    end

    always_comb begin
        reg_data_d  = reg_data_q;
        reg_addr_d  = reg_addr_q;
        reg_write_d = reg_write_q;
        valid_d     = valid_q;
        if (i_flush) begin
            reg_data_d  = '0;
            reg_addr_d  = '0;
            reg_write_d = 1'b0;
            valid_d     = 1'b0;
        end else if (!i_stall) begin
            reg_data_d  = sel_data;
            reg_addr_d  = i_reg_addr;
            reg_write_d = i_valid & i_RegWrite & (i_reg_addr != '0);
            valid_d     = i_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_data_q  <= '0;
            reg_addr_q  <= '0;
            reg_write_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            reg_data_q  <= reg_data_d;
            reg_addr_q  <= reg_addr_d;
            reg_write_q <= reg_write_d;
            valid_q     <= valid_d;
        end
    end

    assign o_reg_data  = reg_data_q;
    assign o_reg_addr  = reg_addr_q;
    assign o_reg_write = reg_write_q;
    assign o_valid     = valid_q;

`ifdef WB_RETIRE_COUNT_EN
    logic [CNT_BITS-1:0] count_q, count_d;

    // Clear wins over a simultaneous increment and works while stalled.
    always_comb begin
        count_d = count_q;
        if (i_valid && !i_stall && !i_flush) count_d = count_q + 1'b1;
        if (i_count_clr) count_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    assign o_retired_count = count_q;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Directed plus randomized bench for write_back_stage against an arithmetic reference model.
module tb_write_back_stage;
    localparam int PB = 32;
    localparam int AB = 5;
    localparam int CB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_stall = 1'b0, i_flush = 1'b0, i_valid = 1'b0, i_RegWrite = 1'b0;
    logic [AB-1:0] i_reg_addr = '0;
    logic [1:0]    i_wb_sel = '0, i_load_size = '0;
    logic          i_load_unsigned = 1'b0;
    logic [1:0]    i_byte_offset = '0;
    logic [PB-1:0] i_alu_data = '0, i_mem_data = '0, i_pc_return = '0;
    logic [PB-1:0] o_reg_data;
    logic [AB-1:0] o_reg_addr;
    logic          o_reg_write, o_valid;
`ifdef WB_RETIRE_COUNT_EN
    logic          i_count_clr = 1'b0;
    logic [CB-1:0] o_retired_count;
`endif

    write_back_stage #(
        .PROC_BITS(PB), .PC_BITS(PB), .REG_ADDRS_BITS(AB)
`ifdef WB_RETIRE_COUNT_EN
        , .CNT_BITS(CB)
`endif
    ) dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
        .i_RegWrite(i_RegWrite), .i_reg_addr(i_reg_addr), .i_wb_sel(i_wb_sel),
        .i_load_size(i_load_size), .i_load_unsigned(i_load_unsigned),
        .i_byte_offset(i_byte_offset), .i_alu_data(i_alu_data), .i_mem_data(i_mem_data),
        .i_pc_return(i_pc_return),
`ifdef WB_RETIRE_COUNT_EN
        .i_count_clr(i_count_clr), .o_retired_count(o_retired_count),
`endif
        .o_reg_data(o_reg_data), .o_reg_addr(o_reg_addr), .o_reg_write(o_reg_write),
        .o_valid(o_valid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [PB-1:0] m_data = '0;
    logic [AB-1:0] m_addr = '0;
    logic          m_we = 1'b0, m_vld = 1'b0;
    int            m_cnt = 0;

    // Expected write-back value from the selection and extension rules.
    function automatic logic [PB-1:0] ref_value(input logic [1:0] sel, input logic [1:0] size,
                                                 input logic uns, input int off,
                                                 input logic [PB-1:0] alu, input logic [PB-1:0] mem,
                                                 input logic [PB-1:0] pc);
        longint lane, w, pos;
        if (sel == 2'b10) return pc;
        if (sel != 2'b01) return alu;
        if (size == 2'b00)      begin w = 8;  pos = off;           end
        else if (size == 2'b01) begin w = 16; pos = (off / 2) * 2; end
        else                    begin w = 32; pos = 0;             end
        lane = (longint'(mem) >> (8 * pos)) % (64'sd1 << w);
        if (!uns && w < 32 && lane >= (64'sd1 << (w - 1))) lane = lane - (64'sd1 << w);
        return lane[PB-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"},  64'(o_reg_data),  64'(m_data));
        chk({tag, ".addr"},  64'(o_reg_addr),  64'(m_addr));
        chk({tag, ".we"},    64'(o_reg_write), 64'(m_we));
        chk({tag, ".valid"}, 64'(o_valid),     64'(m_vld));
`ifdef WB_RETIRE_COUNT_EN
        chk({tag, ".cnt"},   64'(o_retired_count), 64'(m_cnt));
`endif
    endtask

    // Advance the model with the inputs present before the edge, then check just after it.
    task automatic tick(input string tag);
        logic clr;
        clr = 1'b0;
`ifdef WB_RETIRE_COUNT_EN
        clr = i_count_clr;
`endif
        if (i_valid && !i_stall && !i_flush) m_cnt = (m_cnt + 1) % (1 << CB);
        if (clr) m_cnt = 0;
        if (i_flush) begin
            m_data = '0; m_addr = '0; m_we = 1'b0; m_vld = 1'b0;
        end else if (!i_stall) begin
            m_data = ref_value(i_wb_sel, i_load_size, i_load_unsigned, int'(i_byte_offset),
                               i_alu_data, i_mem_data, i_pc_return);
            m_addr = i_reg_addr;
            m_we   = i_valid && i_RegWrite && (i_reg_addr != 0);
            m_vld  = i_valid;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic rand_in();
        i_valid         = 1'($urandom_range(0, 3) != 0);
        i_RegWrite      = 1'($urandom);
        i_reg_addr      = AB'($urandom);
        i_wb_sel        = 2'($urandom);
        i_load_size     = 2'($urandom);
        i_load_unsigned = 1'($urandom);
        i_byte_offset   = 2'($urandom);
        i_alu_data      = $urandom;
        i_mem_data      = $urandom;
        i_pc_return     = $urandom;
    endtask

    task automatic load(input logic [1:0] size, input logic uns, input logic [1:0] off,
                        input logic [PB-1:0] mem, input logic [AB-1:0] addr);
        i_valid = 1'b1; i_RegWrite = 1'b1; i_wb_sel = 2'b01; i_load_size = size;
        i_load_unsigned = uns; i_byte_offset = off; i_mem_data = mem; i_reg_addr = addr;
    endtask

    initial begin
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
`ifdef WB_RETIRE_COUNT_EN
        i_count_clr = 1'b0;
`endif

        load(2'b00, 1'b0, 2'd2, 32'h1280_3456, 5'd7);
        tick("sbyte");
        chk("sbyte.const", 64'(o_reg_data), 64'hFFFF_FF80);

        load(2'b01, 1'b1, 2'd3, 32'h8001_7FFE, 5'd3);
        tick("uhalf3");
        chk("uhalf3.const", 64'(o_reg_data), 64'h0000_8001);
        load(2'b01, 1'b0, 2'd0, 32'h8001_7FFE, 5'd3);
        tick("shalf0");
        chk("shalf0.const", 64'(o_reg_data), 64'h0000_7FFE);
        load(2'b10, 1'b0, 2'd1, 32'h8001_7FFE, 5'd3);
        tick("word");
        chk("word.const", 64'(o_reg_data), 64'h8001_7FFE);

        i_wb_sel = 2'b10; i_pc_return = 32'h40; i_reg_addr = 5'd0;
        tick("pc_r0");
        chk("pc_r0.we", 64'(o_reg_write), 64'd0);
        chk("pc_r0.valid", 64'(o_valid), 64'd1);
        i_reg_addr = 5'd31;
        tick("pc_r31");
        chk("pc_r31.data", 64'(o_reg_data), 64'h40);

        i_wb_sel = 2'b00; i_alu_data = 32'hDEAD_BEEF; i_reg_addr = 5'd9;
        tick("alu");
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_in();
            tick("stall");
            chk("stall.hold", 64'(o_reg_data), 64'hDEAD_BEEF);
        end
        i_flush = 1'b1;
        tick("flush_stall");
        chk("flush.data", 64'(o_reg_data), 64'd0);
        i_stall = 1'b0; i_flush = 1'b0;

        // Asynchronous reset while a write is pending.
        i_valid = 1'b1; i_RegWrite = 1'b1; i_reg_addr = 5'd4; i_wb_sel = 2'b00;
        i_alu_data = 32'h1234_5678;
        tick("pre_rst");
        chk("pre_rst.we", 64'(o_reg_write), 64'd1);
        #2 rst = 1'b0;
        m_data = '0; m_addr = '0; m_we = 1'b0; m_vld = 1'b0; m_cnt = 0;
        #1 check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        tick("post_rst");

`ifdef WB_RETIRE_COUNT_EN
        i_count_clr = 1'b1; i_valid = 1'b0;
        tick("cnt_clr0");
        i_count_clr = 1'b0; i_valid = 1'b1;
        for (int k = 0; k < 5; k++) tick("cnt_inc");
        i_stall = 1'b1; tick("cnt_stall");
        i_stall = 1'b0; i_flush = 1'b1; tick("cnt_flush");
        i_flush = 1'b0;
        chk("cnt.five", 64'(o_retired_count), 64'd5);
        for (int k = 0; k < 10; k++) tick("cnt_fill");
        chk("cnt.ones", 64'(o_retired_count), 64'((1 << CB) - 1));
        tick("cnt_wrap");
        chk("cnt.wrap", 64'(o_retired_count), 64'd0);
        tick("cnt_one");
        i_count_clr = 1'b1;
        tick("cnt_clr_inc");
        chk("cnt.clr_inc", 64'(o_retired_count), 64'd0);
        i_count_clr = 1'b0;
`endif

        for (int n = 0; n < 400; n++) begin
            rand_in();
            i_stall = 1'($urandom_range(0, 4) == 0);
            i_flush = 1'($urandom_range(0, 9) == 0);
`ifdef WB_RETIRE_COUNT_EN
            i_count_clr = 1'($urandom_range(0, 19) == 0);
`endif
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
